aemb2_fetch_unit: RTL and testbench
===================================

# aemb2_fetch_unit

Multi-thread instruction fetch and programme-counter unit for the AEMB2 core, the parametrised successor to the two-phase branch/PC block. It keeps one PC per hardware thread (THR threads, round-robin), drives a Wishbone-style instruction bus that may insert wait states, and buffers fetched words in a 2-entry output queue so decode can back-pressure. Branch redirects from EX are applied per thread, with optional delay slot and squash of wrong-path words.

## Interface
- IWB, 32: instruction address width; iwb_adr_o is [IWB-1:2].
- THR, 2: thread count, legal values 1, 2, 4; TW = max(1, log2(THR)).
- RST_PC, 30'h0: reset PC of every thread (word address).

- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- iwb_adr_o  out  IWB-2  fetch word address.
- iwb_stb_o  out  1  fetch request; held until iwb_ack_i.
- iwb_dat_i  in  32  fetched instruction word.
- iwb_ack_i  in  1  fetch complete; ignored when iwb_stb_o=0.
- bra_i  in  1  branch taken, one-cycle pulse.
- bra_thr_i  in  TW  thread of the branch.
- bra_tgt_i  in  30  branch target [31:2].
- bra_dly_i  in  1  1 = branch has a delay slot.
- hold_i  in  1  decode stall; queue head not consumed.
- ins_o  out  32  queue head instruction.
- ins_pc_o  out  30  PC of ins_o.
- ins_thr_o  out  TW  thread of ins_o.
- ins_vld_o  out  1  queue non-empty.

## Operation
- State per thread t: PC[t] (30b), PND[t] (redirect pending), DLY[t] (delay slot outstanding), TGT[t] (30b).
- Fetch FSM, two states: IDLE (stb=0), BUSY (stb=1, adr=PC[cur][IWB-1:2], cur = round-robin thread pointer).
- Issue rule: enter/stay BUSY when queue occupancy after this cycle's push/pop ≤ 1; otherwise IDLE. BUSY exits only via ack; adr/stb stable while waiting.
- On ack for thread c (with pre-cycle PND/DLY):
  - PND[c]=0: push {dat, PC[c], c}; PC[c] <= PC[c]+1 (30-bit wrap).
  - PND[c]=1, DLY[c]=1: push word (delay slot); PC[c] <= PC[c]+1; DLY[c] <= 0.
  - PND[c]=1, DLY[c]=0: word squashed (no push); PC[c] <= TGT[c]; PND[c] <= 0.
  - cur <= cur+1 mod THR.
- On bra_i for thread b: PND[b]<=1, TGT[b]<=bra_tgt_i. Queue entries of thread b: if bra_dly_i=1 and one exists, oldest is kept as delay slot, DLY[b]<=0, others invalidated; if none buffered, DLY[b]<=1. If bra_dly_i=0, all thread-b entries invalidated, DLY[b]<=0. In-flight fetch of b is then squashed by ack rule.
- bra_i and ack same cycle, same thread: ack uses pre-cycle state; branch state written after (branch wins). Repeated bra_i on pending thread overwrites TGT/DLY.
- Queue: 2 entries, FIFO order; pop when ins_vld_o=1 and hold_i=0; invalidated entries removed and survivors compacted toward head the same cycle.
- THR=1: cur constant 0.

## Timing
- Reset (async): all PC[t]=RST_PC, PND=DLY=0, cur=0, FSM IDLE, iwb_stb_o=0, iwb_adr_o=RST_PC[IWB-1:2], queue empty, ins_vld_o=0, ins_o=0, ins_pc_o=0, ins_thr_o=0.
- First cycle after reset release: BUSY, stb=1.
- Zero-wait ack: word at ins_o one cycle after ack; sustained 1 word/cycle with hold_i=0.
- Queue full (2) blocks issue; issue resumes the cycle after a pop.
- Reset asserted mid-fetch: stb drops immediately; outstanding ack discarded.

## Test plan
- THR=2, RST_PC=0, zero-wait ack, hold_i=0 -> adr sequence 0,0,1,1,2,2; ins_thr_o 0,1,0,1; ins_vld_o high every cycle from 2nd cycle after reset release.
- Ack delayed 3 cycles each -> stb and adr held stable 4 cycles per fetch; no duplicate or lost words.
- hold_i=1 for 5 cycles -> queue fills to 2, stb low, ins_o unchanged; release -> words delivered in order, no gaps.
- bra_i thr0, tgt=0x100, dly=0, thr0 word at PC 5 buffered and PC 6 in flight -> both dropped; next thr0 ins_pc_o=0x100; thr1 stream unaffected.
- bra_i thr1, tgt=0x40, dly=1, nothing buffered -> next thr1 word (PC+1) delivered, following thr1 word 0x40.
- bra_i coincident with ack of same thread, dly=0 -> acked word pushed, next fetch of that thread squashed, then target fetched.

Source files
------------

// File: rtl/aemb2_fetch_unit_if.sv
// Signal bundle of the AEMB2 fetch unit: instruction bus, EX branch redirect
// and the decode-side instruction queue head.
interface aemb2_fetch_unit_if #(
    parameter int IWB = 32,
    parameter int TW  = 1
);
    logic [IWB-3:0] iwb_adr_o;
    logic           iwb_stb_o;
    logic [31:0]    iwb_dat_i;
    logic           iwb_ack_i;
    logic           bra_i;
    logic [TW-1:0]  bra_thr_i;
    logic [29:0]    bra_tgt_i;
    logic           bra_dly_i;
    logic           hold_i;
    logic [31:0]    ins_o;
    logic [29:0]    ins_pc_o;
    logic [TW-1:0]  ins_thr_o;
    logic           ins_vld_o;

    modport master (
        output iwb_adr_o, iwb_stb_o, ins_o, ins_pc_o, ins_thr_o, ins_vld_o,
        input  iwb_dat_i, iwb_ack_i, bra_i, bra_thr_i, bra_tgt_i, bra_dly_i, hold_i
    );

    modport slave (
        input  iwb_adr_o, iwb_stb_o, ins_o, ins_pc_o, ins_thr_o, ins_vld_o,
        output iwb_dat_i, iwb_ack_i, bra_i, bra_thr_i, bra_tgt_i, bra_dly_i, hold_i
    );
endinterface

// File: rtl/aemb2_fetch_unit.sv
// AEMB2 multi-thread fetch unit: round-robin per-thread PCs, a wait-state
// tolerant instruction bus, branch redirect with delay slot, 2-entry queue.
module aemb2_fetch_unit #(
    parameter int          IWB    = 32,
    parameter int          THR    = 2,
    parameter logic [29:0] RST_PC = 30'h0,
    localparam int         TW     = (THR > 1) ? $clog2(THR) : 1
) (
    input logic                clk_i,
    input logic                rst_i,
    aemb2_fetch_unit_if.master bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic          vld;
        logic [TW-1:0] thr;
        logic [29:0]   pc;
        logic [31:0]   dat;
    } entry_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  cur;
    logic [29:0]    pc  [THR];
    logic [29:0]    tgt [THR];
    logic [THR-1:0] pnd, dly;
    entry_t         q     [2];
    entry_t         q_nxt [2];
    entry_t         fetched;
    logic           ack, pop, push, bra_kept;

    assign ack  = (state == BUSY) && bus.iwb_ack_i;
    assign pop  = q[0].vld && !bus.hold_i;
    assign push = ack && (!pnd[cur] || dly[cur]);

    assign fetched = '{vld: 1'b1, thr: cur, pc: pc[cur], dat: bus.iwb_dat_i};

    // The head popped this cycle is already in decode, so a branch only
    // inspects the entries that remain behind it; the word acked in the same
    // cycle is not subject to the branch.
    always_comb begin
        // NOTE: combinational temporaries use blocking '=' so each step sees
        // the previous one; every output is assigned before any branch, so
        // no latch can be inferred.
        q_nxt[0] = pop ? q[1] : q[0];
        q_nxt[1] = pop ? '0   : q[1];
        bra_kept = 1'b0;
        if (bus.bra_i) begin
            for (int i = 0; i < 2; i++) begin
                if (q_nxt[i].vld && q_nxt[i].thr == bus.bra_thr_i) begin
                    if (bus.bra_dly_i && !bra_kept) bra_kept = 1'b1;
                    else                            q_nxt[i] = '0;
                end
            end
        end
        if (!q_nxt[0].vld) begin
            q_nxt[0] = q_nxt[1];
            q_nxt[1] = '0;
        end
        if (push) begin
            if (!q_nxt[0].vld) q_nxt[0] = fetched;
            else               q_nxt[1] = fetched;
        end
    end

    // A compacted queue holds at most one word exactly when slot 1 is empty.
    always_comb begin
        state_nxt = state;
        if (state == IDLE || ack)
            state_nxt = q_nxt[1].vld ? IDLE : BUSY;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cur   <= '0;
            pnd   <= '0;
            dly   <= '0;
            // NOTE: these arrays are small flop banks, not RAM, so every
            // element gets a defined reset value.
            for (int t = 0; t < THR; t++) begin
                pc[t]  <= RST_PC;
                tgt[t] <= '0;
            end
            q[0] <= '0;
            q[1] <= '0;
        end else begin
            state <= state_nxt;
            q[0]  <= q_nxt[0];
            q[1]  <= q_nxt[1];
            if (ack) begin
                if (!pnd[cur] || dly[cur]) pc[cur] <= pc[cur] + 30'd1;
                else                       pc[cur] <= tgt[cur];
                if (pnd[cur]) begin
                    if (dly[cur]) dly[cur] <= 1'b0;
                    else          pnd[cur] <= 1'b0;
                end
                cur <= (THR == 1) ? '0 : cur + TW'(1);
            end
            // Later assignments win, so a coincident branch overrides the ack update.
            if (bus.bra_i) begin
                pnd[bus.bra_thr_i] <= 1'b1;
                tgt[bus.bra_thr_i] <= bus.bra_tgt_i;
                dly[bus.bra_thr_i] <= bus.bra_dly_i && !bra_kept;
            end
        end
    end

    assign bus.iwb_stb_o = (state == BUSY);
    assign bus.iwb_adr_o = pc[cur][IWB-3:0];
    assign bus.ins_vld_o = q[0].vld;
    assign bus.ins_o     = q[0].dat;
    assign bus.ins_pc_o  = q[0].pc;
    assign bus.ins_thr_o = q[0].thr;
endmodule

// File: tb/tb_aemb2_fetch_unit.sv
// Directed bench for aemb2_fetch_unit (THR=2): streaming, wait states,
// decode hold, branch redirects with and without delay slot, reset mid-fetch.
module tb_aemb2_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n     = 0;
    int   wait_n = 0;
    int   wcnt   = 0;

    aemb2_fetch_unit_if #(.IWB(32), .TW(1)) bus ();

    aemb2_fetch_unit #(.IWB(32), .THR(2), .RST_PC(30'h0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Bus slave: acks after wait_n idle cycles of a held strobe.
    always @(negedge clk) begin
        bus.iwb_dat_i = mem_word(bus.iwb_adr_o);
        if (rst || !bus.iwb_stb_o) begin
            bus.iwb_ack_i = 1'b0;
            wcnt = 0;
        end else if (wcnt >= wait_n) begin
            bus.iwb_ack_i = 1'b1;
            wcnt = 0;
        end else begin
            bus.iwb_ack_i = 1'b0;
            wcnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic thr, input logic [29:0] pc);
        check({tag, "_vld"}, 64'(bus.ins_vld_o), 64'd1);
        check({tag, "_thr"}, 64'(bus.ins_thr_o), 64'(thr));
        check({tag, "_pc"},  64'(bus.ins_pc_o),  64'(pc));
        check({tag, "_ins"}, 64'(bus.ins_o),     64'(mem_word(pc)));
    endtask

    task automatic goto(input int k);
        while (n < k) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_stb", 64'(bus.iwb_stb_o), 64'd0);
        check("rst_adr", 64'(bus.iwb_adr_o), 64'd0);
        check("rst_vld", 64'(bus.ins_vld_o), 64'd0);
        check("rst_ins", 64'(bus.ins_o),     64'd0);
        check("rst_pc",  64'(bus.ins_pc_o),  64'd0);
        check("rst_thr", 64'(bus.ins_thr_o), 64'd0);
        rst = 1'b0;
        n = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] a_adr [6]  = '{0, 0, 1, 1, 2, 2};
        logic        a_thr [5]  = '{0, 1, 0, 1, 0};
        logic [29:0] a_pc  [5]  = '{0, 0, 1, 1, 2};
        logic [29:0] b_adr [9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic        b_vld [9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

        bus.iwb_dat_i = '0;
        bus.iwb_ack_i = 1'b0;
        bus.bra_i     = 1'b0;
        bus.bra_thr_i = '0;
        bus.bra_tgt_i = '0;
        bus.bra_dly_i = 1'b0;
        bus.hold_i    = 1'b0;

        // Zero-wait streaming, then decode hold for five cycles.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            goto(k);
            check("a_stb", 64'(bus.iwb_stb_o), 64'd1);
            check("a_adr", 64'(bus.iwb_adr_o), 64'(a_adr[k-1]));
            if (k >= 2) check_head("a_head", a_thr[k-2], a_pc[k-2]);
            else        check("a_vld0", 64'(bus.ins_vld_o), 64'd0);
        end
        bus.hold_i = 1'b1;
        for (int k = 7; k <= 11; k++) begin
            goto(k);
            check("c_stb", 64'(bus.iwb_stb_o), 64'd0);
            check_head("c_held", 1'b0, 30'd2);
        end
        bus.hold_i = 1'b0;
        goto(12);
        check("c_stb_resume", 64'(bus.iwb_stb_o), 64'd1);
        check("c_adr_resume", 64'(bus.iwb_adr_o), 64'd3);
        check_head("c_rel1", 1'b1, 30'd2);
        goto(13); check_head("c_rel2", 1'b0, 30'd3);
        goto(14); check_head("c_rel3", 1'b1, 30'd3);
        goto(15); check_head("c_rel4", 1'b0, 30'd4);

        // Three wait states per fetch; thread-1 branch with delay slot, nothing buffered.
        wait_n = 3;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            goto(k);
            check("b_stb", 64'(bus.iwb_stb_o), 64'd1);
            check("b_adr", 64'(bus.iwb_adr_o), 64'(b_adr[k-1]));
            check("b_vld", 64'(bus.ins_vld_o), 64'(b_vld[k-1]));
        end
        check_head("b_w0", 1'b1, 30'd0);
        goto(10);
        check("e_empty", 64'(bus.ins_vld_o), 64'd0);
        bus.bra_i = 1'b1; bus.bra_thr_i = 1'b1; bus.bra_tgt_i = 30'h40; bus.bra_dly_i = 1'b1;
        goto(11);
        bus.bra_i = 1'b0; bus.bra_dly_i = 1'b0;
        goto(13); check_head("e_t0p1", 1'b0, 30'd1);
        check("e_adr13", 64'(bus.iwb_adr_o), 64'd1);
        goto(17); check_head("e_dslot", 1'b1, 30'd1);
        goto(21); check_head("e_t0p2", 1'b0, 30'd2);
        goto(24); check("e_sq_adr", 64'(bus.iwb_adr_o), 64'd2);
        goto(25);
        check("e_sq_vld", 64'(bus.ins_vld_o), 64'd0);
        check("e_adr25", 64'(bus.iwb_adr_o), 64'd3);
        goto(29); check_head("e_t0p3", 1'b0, 30'd3);
        check("e_tgt_adr", 64'(bus.iwb_adr_o), 64'h40);
        goto(33); check_head("e_tgt", 1'b1, 30'h40);
        check("e_stb33", 64'(bus.iwb_stb_o), 64'd1);
        goto(34);
        rst = 1'b1;
        #1;
        check("mid_rst_stb", 64'(bus.iwb_stb_o), 64'd0);
        check("mid_rst_vld", 64'(bus.ins_vld_o), 64'd0);

        // Thread-0 branch without delay slot while its PC 5 word is buffered.
        wait_n = 0;
        do_reset();
        goto(2);
        check("d_first_vld", 64'(bus.ins_vld_o), 64'd1);
        goto(12);
        check_head("d_t0p5", 1'b0, 30'd5);
        check("d_adr12", 64'(bus.iwb_adr_o), 64'd5);
        bus.hold_i = 1'b1;
        goto(13);
        check("d_full_stb", 64'(bus.iwb_stb_o), 64'd0);
        check_head("d_held", 1'b0, 30'd5);
        bus.bra_i = 1'b1; bus.bra_thr_i = 1'b0; bus.bra_tgt_i = 30'h100; bus.bra_dly_i = 1'b0;
        goto(14);
        bus.bra_i = 1'b0; bus.hold_i = 1'b0;
        check_head("d_t1p5", 1'b1, 30'd5);
        check("d_adr14", 64'(bus.iwb_adr_o), 64'd6);
        goto(15);
        check("d_sq_vld", 64'(bus.ins_vld_o), 64'd0);
        goto(16); check_head("d_t1p6", 1'b1, 30'd6);
        check("d_adr16", 64'(bus.iwb_adr_o), 64'h100);
        goto(17); check_head("d_tgt", 1'b0, 30'h100);
        goto(18); check_head("d_t1p7", 1'b1, 30'd7);

        // Thread-1 branch coincident with its own ack, no delay slot.
        do_reset();
        goto(4);
        check("f_adr4", 64'(bus.iwb_adr_o), 64'd1);
        bus.bra_i = 1'b1; bus.bra_thr_i = 1'b1; bus.bra_tgt_i = 30'h20; bus.bra_dly_i = 1'b0;
        goto(5);
        bus.bra_i = 1'b0;
        check_head("f_acked", 1'b1, 30'd1);
        goto(6); check_head("f_t0p2", 1'b0, 30'd2);
        check("f_adr6", 64'(bus.iwb_adr_o), 64'd2);
        goto(7);
        check("f_sq_vld", 64'(bus.ins_vld_o), 64'd0);
        check("f_adr7", 64'(bus.iwb_adr_o), 64'd3);
        goto(8); check_head("f_t0p3", 1'b0, 30'd3);
        check("f_adr8", 64'(bus.iwb_adr_o), 64'h20);
        goto(9); check_head("f_tgt", 1'b1, 30'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
